// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl
// Brief    : Hazard and pipeline controller for the in-order RV32I core.
//            Produces PC enable/load, per-register enable/flush, the redirect
//            target, a wrong-path fetch squash FSM and saturating counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_ctrl #(
  parameter int NUM_STAGES  = 5,
  parameter int XLEN        = 32,
  parameter int LU_BUBBLES  = 1,
  parameter int FLUSH_DEPTH = 2,
  parameter int PERF_W      = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    imem_resp_i,
  input  logic                    dmem_read_i,
  input  logic                    dmem_write_i,
  input  logic                    dmem_resp_i,
  input  logic [4:0]              rs1_id_i,
  input  logic [4:0]              rs2_id_i,
  input  logic                    rs1_used_i,
  input  logic                    rs2_used_i,
  input  logic                    ex_is_load_i,
  input  logic [4:0]              rd_ex_i,
  input  logic                    ex_redirect_i,
  input  logic [XLEN-1:0]         ex_target_i,
  input  logic                    cnt_clr_i,
  output logic                    pc_en_o,
  output logic                    pc_load_o,
  output logic [XLEN-1:0]         pc_target_o,
  output logic [NUM_STAGES-2:0]   preg_en_o,
  output logic [NUM_STAGES-2:0]   preg_flush_o,
  output logic [PERF_W-1:0]       stall_cycles_o,
  output logic [PERF_W-1:0]       redirect_count_o,
  output logic [PERF_W-1:0]       lu_count_o
);

  localparam int NR = NUM_STAGES - 1;

  // Register-index masks: IF/ID only, ID/EX only, all, and the redirect flush set
  localparam logic [NR-1:0] C_ALL        = {NR{1'b1}};
  localparam logic [NR-1:0] C_BIT0       = {{(NR-1){1'b0}}, 1'b1};
  localparam logic [NR-1:0] C_BIT1       = C_BIT0 << 1;
  localparam logic [NR-1:0] C_FLUSH_MASK = C_ALL >> (NR - FLUSH_DEPTH);
  localparam logic [2:0]    C_LU_INIT    = 3'(LU_BUBBLES - 1);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       lu_cnt_q, lu_cnt_d;
  logic             redir_inc_w, lu_inc_w;
  logic             dmem_ok_w, lu_hit_w;
  logic [2:0]       cnt_inc_w;
  logic [PERF_W-1:0] cnt_q [3];

  assign dmem_ok_w = dmem_resp_i | ~(dmem_read_i | dmem_write_i);

  // x0 is hard-wired zero, so a load targeting it never creates a dependency
  assign lu_hit_w = ex_is_load_i & (rd_ex_i != 5'd0) &
                    ((rs1_used_i & (rs1_id_i == rd_ex_i)) |
                     (rs2_used_i & (rs2_id_i == rd_ex_i)));

  assign pc_target_o = ex_target_i;

  // Prioritised control decode; all outputs forced low while reset is held
  always_comb begin
    pc_en_o      = 1'b0;
    pc_load_o    = 1'b0;
    preg_en_o    = '0;
    preg_flush_o = '0;
    state_d      = state_q;
    lu_cnt_d     = lu_cnt_q;
    redir_inc_w  = 1'b0;
    lu_inc_w     = 1'b0;

    if (!dmem_ok_w) begin
      // Memory stall: everything freezes, a pending redirect waits
    end else if (ex_redirect_i) begin
      pc_en_o      = 1'b1;
      pc_load_o    = 1'b1;
      preg_en_o    = C_ALL;
      preg_flush_o = C_FLUSH_MASK;
      lu_cnt_d     = 3'd0;
      redir_inc_w  = 1'b1;
      // A fetch still in flight belongs to the wrong path and must be dropped
      state_d      = imem_resp_i ? ST_RUN : ST_DRAIN;
    end else if (state_q == ST_DRAIN) begin
      preg_en_o    = C_ALL;
      preg_flush_o = C_BIT0;
      if (imem_resp_i) state_d = ST_RUN;
    end else if (lu_hit_w || (lu_cnt_q != 3'd0)) begin
      // Hold PC and IF/ID, inject a bubble into ID/EX
      preg_en_o    = C_ALL & ~C_BIT0;
      preg_flush_o = C_BIT1;
      if (lu_hit_w && (lu_cnt_q == 3'd0)) begin
        lu_cnt_d = C_LU_INIT;
        lu_inc_w = 1'b1;
      end else begin
        lu_cnt_d = lu_cnt_q - 3'd1;
      end
    end else if (imem_resp_i) begin
      pc_en_o   = 1'b1;
      preg_en_o = C_ALL;
    end else begin
      // I-cache miss: keep the pipe moving with a bubble behind the fetch
      preg_en_o    = C_ALL;
      preg_flush_o = C_BIT0;
    end

    if (!rst_ni) begin
      pc_en_o      = 1'b0;
      pc_load_o    = 1'b0;
      preg_en_o    = '0;
      preg_flush_o = '0;
    end
  end

  // FSM state and load-use bubble counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_RUN;
      lu_cnt_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      lu_cnt_q <= lu_cnt_d;
    end
  end

  assign cnt_inc_w = {lu_inc_w, redir_inc_w, ~pc_en_o};

  // Saturating performance counters; clear beats increment
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (cnt_clr_i) begin
          cnt_q[i] <= '0;
        end else if (cnt_inc_w[i] && (cnt_q[i] != {PERF_W{1'b1}})) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign stall_cycles_o   = cnt_q[0];
  assign redirect_count_o = cnt_q[1];
  assign lu_count_o       = cnt_q[2];

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_ctrl
// Brief    : Directed self-checking bench for pipeline_ctrl
//            (LU_BUBBLES=2, PERF_W=4, NUM_STAGES=5, FLUSH_DEPTH=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        imem_resp_i, dmem_read_i, dmem_write_i, dmem_resp_i;
  logic [4:0]  rs1_id_i, rs2_id_i, rd_ex_i;
  logic        rs1_used_i, rs2_used_i, ex_is_load_i, ex_redirect_i, cnt_clr_i;
  logic [31:0] ex_target_i;
  logic        pc_en_o, pc_load_o;
  logic [31:0] pc_target_o;
  logic [3:0]  preg_en_o, preg_flush_o;
  logic [3:0]  stall_cycles_o, redirect_count_o, lu_count_o;

  int n_run  = 0;
  int n_fail = 0;

  pipeline_ctrl #(
    .NUM_STAGES(5), .XLEN(32), .LU_BUBBLES(2), .FLUSH_DEPTH(2), .PERF_W(4)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .imem_resp_i(imem_resp_i), .dmem_read_i(dmem_read_i),
    .dmem_write_i(dmem_write_i), .dmem_resp_i(dmem_resp_i),
    .rs1_id_i(rs1_id_i), .rs2_id_i(rs2_id_i),
    .rs1_used_i(rs1_used_i), .rs2_used_i(rs2_used_i),
    .ex_is_load_i(ex_is_load_i), .rd_ex_i(rd_ex_i),
    .ex_redirect_i(ex_redirect_i), .ex_target_i(ex_target_i),
    .cnt_clr_i(cnt_clr_i),
    .pc_en_o(pc_en_o), .pc_load_o(pc_load_o), .pc_target_o(pc_target_o),
    .preg_en_o(preg_en_o), .preg_flush_o(preg_flush_o),
    .stall_cycles_o(stall_cycles_o), .redirect_count_o(redirect_count_o),
    .lu_count_o(lu_count_o)
  );

  always #5 clk_i = ~clk_i;

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    imem_resp_i = 1'b1; dmem_read_i = 1'b0; dmem_write_i = 1'b0; dmem_resp_i = 1'b1;
    rs1_id_i = 5'd0; rs2_id_i = 5'd0; rs1_used_i = 1'b0; rs2_used_i = 1'b0;
    ex_is_load_i = 1'b0; rd_ex_i = 5'd0; ex_redirect_i = 1'b0;
    ex_target_i = 32'h0; cnt_clr_i = 1'b0;
  endtask

  task automatic clear_counters();
    cnt_clr_i = 1'b1;
    step();
    cnt_clr_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    idle_inputs();
    step(); step();
    n_run++;
    if ({pc_en_o, pc_load_o, preg_en_o, preg_flush_o} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got en=%b ld=%b pen=%b pfl=%b want all 0",
               pc_en_o, pc_load_o, preg_en_o, preg_flush_o);
    end
    n_run++;
    if ({stall_cycles_o, redirect_count_o, lu_count_o} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_cnt: got %0d/%0d/%0d want 0/0/0",
               stall_cycles_o, redirect_count_o, lu_count_o);
    end
    rst_ni = 1'b1;
    #1;
    n_run++;
    if ({pc_en_o, pc_load_o, preg_en_o, preg_flush_o} !== {1'b1, 1'b0, 4'b1111, 4'b0000}) begin
      n_fail++;
      $display("FAIL idle_run: got en=%b ld=%b pen=%b pfl=%b want 1 0 1111 0000",
               pc_en_o, pc_load_o, preg_en_o, preg_flush_o);
    end
  endtask

  task automatic test_load_use();
    clear_counters();
    ex_is_load_i = 1'b1; rd_ex_i = 5'd5; rs2_id_i = 5'd5; rs2_used_i = 1'b1;
    rs1_id_i = 5'd7; rs1_used_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_run++;
      if ({pc_en_o, preg_en_o, preg_flush_o} !== {1'b0, 4'b1110, 4'b0010}) begin
        n_fail++;
        $display("FAIL lu_stall c%0d: got en=%b pen=%b pfl=%b want 0 1110 0010",
                 c, pc_en_o, preg_en_o, preg_flush_o);
      end
      step();
    end
    // Bubble has reached EX: the load is gone
    ex_is_load_i = 1'b0;
    #1;
    n_run++;
    if (pc_en_o !== 1'b1) begin
      n_fail++;
      $display("FAIL lu_resume: got pc_en=%b want 1", pc_en_o);
    end
    n_run++;
    if ({lu_count_o, stall_cycles_o} !== {4'd1, 4'd2}) begin
      n_fail++;
      $display("FAIL lu_counters: got lu=%0d stall=%0d want lu=1 stall=2",
               lu_count_o, stall_cycles_o);
    end
    idle_inputs();
  endtask

  task automatic test_x0_load();
    clear_counters();
    ex_is_load_i = 1'b1; rd_ex_i = 5'd0; rs1_id_i = 5'd0; rs1_used_i = 1'b1;
    #1;
    n_run++;
    if ({pc_en_o, preg_flush_o} !== {1'b1, 4'b0000}) begin
      n_fail++;
      $display("FAIL x0_no_stall: got en=%b pfl=%b want 1 0000", pc_en_o, preg_flush_o);
    end
    step();
    n_run++;
    if (lu_count_o !== 4'd0) begin
      n_fail++;
      $display("FAIL x0_lu_count: got %0d want 0", lu_count_o);
    end
    idle_inputs();
  endtask

  task automatic test_redirect_drain();
    clear_counters();
    ex_redirect_i = 1'b1; ex_target_i = 32'h6000_0040; imem_resp_i = 1'b0;
    #1;
    n_run++;
    if ({pc_en_o, pc_load_o, pc_target_o, preg_en_o, preg_flush_o} !==
        {1'b1, 1'b1, 32'h6000_0040, 4'b1111, 4'b0011}) begin
      n_fail++;
      $display("FAIL redir_apply: got en=%b ld=%b tgt=%h pen=%b pfl=%b want 1 1 60000040 1111 0011",
               pc_en_o, pc_load_o, pc_target_o, preg_en_o, preg_flush_o);
    end
    step();
    ex_redirect_i = 1'b0; imem_resp_i = 1'b1;
    #1;
    n_run++;
    if ({pc_en_o, pc_load_o, preg_en_o, preg_flush_o} !== {1'b0, 1'b0, 4'b1111, 4'b0001}) begin
      n_fail++;
      $display("FAIL drain_discard: got en=%b ld=%b pen=%b pfl=%b want 0 0 1111 0001",
               pc_en_o, pc_load_o, preg_en_o, preg_flush_o);
    end
    step();
    n_run++;
    if ({pc_en_o, preg_flush_o} !== {1'b1, 4'b0000}) begin
      n_fail++;
      $display("FAIL drain_to_run: got en=%b pfl=%b want 1 0000", pc_en_o, preg_flush_o);
    end
    n_run++;
    if (redirect_count_o !== 4'd1) begin
      n_fail++;
      $display("FAIL drain_redir_cnt: got %0d want 1", redirect_count_o);
    end
    idle_inputs();
  endtask

  task automatic test_dmem_freeze();
    clear_counters();
    dmem_read_i = 1'b1; dmem_resp_i = 1'b0; ex_redirect_i = 1'b1; ex_target_i = 32'h0000_1000;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_run++;
      if ({pc_en_o, pc_load_o, preg_en_o} !== {1'b0, 1'b0, 4'b0000}) begin
        n_fail++;
        $display("FAIL dmem_freeze c%0d: got en=%b ld=%b pen=%b want 0 0 0000",
                 c, pc_en_o, pc_load_o, preg_en_o);
      end
      step();
    end
    dmem_resp_i = 1'b1;
    #1;
    n_run++;
    if ({pc_en_o, pc_load_o, preg_flush_o} !== {1'b1, 1'b1, 4'b0011}) begin
      n_fail++;
      $display("FAIL dmem_late_redir: got en=%b ld=%b pfl=%b want 1 1 0011",
               pc_en_o, pc_load_o, preg_flush_o);
    end
    step();
    n_run++;
    if ({redirect_count_o, stall_cycles_o} !== {4'd1, 4'd3}) begin
      n_fail++;
      $display("FAIL dmem_counters: got redir=%0d stall=%0d want 1 3",
               redirect_count_o, stall_cycles_o);
    end
    idle_inputs();
  endtask

  task automatic test_redirect_vs_lu();
    clear_counters();
    ex_redirect_i = 1'b1; ex_target_i = 32'h0000_0200;
    ex_is_load_i = 1'b1; rd_ex_i = 5'd9; rs1_id_i = 5'd9; rs1_used_i = 1'b1;
    #1;
    n_run++;
    if ({pc_en_o, pc_load_o, preg_en_o, preg_flush_o} !== {1'b1, 1'b1, 4'b1111, 4'b0011}) begin
      n_fail++;
      $display("FAIL redir_wins: got en=%b ld=%b pen=%b pfl=%b want 1 1 1111 0011",
               pc_en_o, pc_load_o, preg_en_o, preg_flush_o);
    end
    step();
    n_run++;
    if ({lu_count_o, redirect_count_o} !== {4'd0, 4'd1}) begin
      n_fail++;
      $display("FAIL redir_lu_counts: got lu=%0d redir=%0d want 0 1",
               lu_count_o, redirect_count_o);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_drain();
    ex_redirect_i = 1'b1; imem_resp_i = 1'b0;
    step();
    ex_redirect_i = 1'b0; imem_resp_i = 1'b1;
    #1;
    n_run++;
    if (preg_flush_o !== 4'b0001) begin
      n_fail++;
      $display("FAIL mid_drain_state: got pfl=%b want 0001", preg_flush_o);
    end
    rst_ni = 1'b0;
    #1;
    n_run++;
    if ({pc_en_o, pc_load_o, preg_en_o, preg_flush_o} !== 10'b0) begin
      n_fail++;
      $display("FAIL async_reset: got en=%b ld=%b pen=%b pfl=%b want all 0",
               pc_en_o, pc_load_o, preg_en_o, preg_flush_o);
    end
    rst_ni = 1'b1;
    #1;
    n_run++;
    if ({pc_en_o, preg_flush_o} !== {1'b1, 4'b0000}) begin
      n_fail++;
      $display("FAIL post_reset_run: got en=%b pfl=%b want 1 0000", pc_en_o, preg_flush_o);
    end
    step();
    idle_inputs();
  endtask

  task automatic test_saturation();
    clear_counters();
    imem_resp_i = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (c == 0) begin
        n_run++;
        if ({pc_en_o, preg_en_o, preg_flush_o} !== {1'b0, 4'b1111, 4'b0001}) begin
          n_fail++;
          $display("FAIL imiss_bubble: got en=%b pen=%b pfl=%b want 0 1111 0001",
                   pc_en_o, preg_en_o, preg_flush_o);
        end
      end
      if (c == 10) begin
        n_run++;
        if (stall_cycles_o !== 4'd10) begin
          n_fail++;
          $display("FAIL stall_mid: got %0d want 10", stall_cycles_o);
        end
      end
      step();
    end
    n_run++;
    if (stall_cycles_o !== 4'd15) begin
      n_fail++;
      $display("FAIL stall_saturate: got %0d want 15", stall_cycles_o);
    end
    cnt_clr_i = 1'b1;
    step();
    cnt_clr_i = 1'b0;
    n_run++;
    if (stall_cycles_o !== 4'd0) begin
      n_fail++;
      $display("FAIL cnt_clr: got %0d want 0", stall_cycles_o);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_x0_load();
    test_redirect_drain();
    test_dmem_freeze();
    test_redirect_vs_lu();
    test_reset_mid_drain();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
